// File: rtl/spi_cfg_pkg.sv
// spi_cfg_pkg: shared definitions for the SPI control path.
//   arb_state_t   - arbiter FSM state encoding
//   CMD_WR/CMD_RD - spi_cmd codes understood by the transaction engine
//   DEFAULT_WIDTH - default transaction bit count
package spi_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    localparam logic [1:0] CMD_WR        = 2'b00;
    localparam logic [1:0] CMD_RD        = 2'b01;
    localparam logic [7:0] DEFAULT_WIDTH = 8'd24;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin first-one finder.
//   i_req   [N_REQ-1:0] request vector
//   i_ptr   [2:0]       highest-priority index (must be < N_REQ)
//   o_valid             at least one request is set
//   o_idx   [2:0]       first set request searching i_ptr, i_ptr+1, ... with wrap
module rr_pick #(
    parameter int unsigned N_REQ = 3
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [2:0]       i_ptr,
    output logic             o_valid,
    output logic [2:0]       o_idx
);

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            int unsigned j;
            j = {29'd0, i_ptr} + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!o_valid && i_req[j]) begin
                o_valid = 1'b1;
                o_idx   = 3'(j);
            end
        end
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin arbiter sharing one SPI transaction engine
// between N_REQ requesters. Serializes transactions, latches the winner's
// fields and returns a one-cycle ack per completed transaction.
//   clk, rst_n        control clock, async active-low reset
//   req/req_cmd/req_wrdata/req_width  per-requester request level and fields
//   ack, err          one-cycle completion / timeout-abort pulses
//   busy, grant_id    arbiter occupied, current or most recent winner
//   spi_start/spi_cmd/spi_wrdata/spi_width/spi_done  engine handshake
// Optional feature: define SPI_ARB_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYC cycles without spi_done (err pulse instead of ack).
module spi_txn_arbiter
    import spi_cfg_pkg::*;
#(
    parameter int unsigned N_REQ       = 3,
    parameter int unsigned DATA_W      = 24,
    parameter logic [15:0] TIMEOUT_CYC = 16'd4095
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [2*N_REQ-1:0]      req_cmd,
    input  logic [DATA_W*N_REQ-1:0] req_wrdata,
    input  logic [8*N_REQ-1:0]      req_width,
    output logic [N_REQ-1:0]        ack,
    output logic [N_REQ-1:0]        err,
    output logic                    busy,
    output logic [2:0]              grant_id,
    output logic                    spi_start,
    output logic [1:0]              spi_cmd,
    output logic [DATA_W-1:0]       spi_wrdata,
    output logic [7:0]              spi_width,
    input  logic                    spi_done
);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [2:0]          r_ptr;
    logic [2:0]          r_grant;
    logic [N_REQ-1:0]    r_ack;
    logic [1:0]          r_cmd;
    logic [DATA_W-1:0]   r_wrdata;
    logic [7:0]          r_width;
    logic                w_valid;
    logic [2:0]          w_idx;
    logic [1:0]          w_sel_cmd;
    logic [DATA_W-1:0]   w_sel_wrdata;
    logic [7:0]          w_sel_width;
    logic                w_timeout;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_valid (w_valid),
        .o_idx   (w_idx)
    );

    // Winner's field slices, selected by mux to avoid a narrow index product.
    always_comb begin
        w_sel_cmd    = '0;
        w_sel_wrdata = '0;
        w_sel_width  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_idx == 3'(i)) begin
                w_sel_cmd    = req_cmd[2*i +: 2];
                w_sel_wrdata = req_wrdata[DATA_W*i +: DATA_W];
                w_sel_width  = req_width[8*i +: 8];
            end
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    logic [15:0]      r_cnt;
    logic [N_REQ-1:0] r_err;

    // Counter is 0 in the first WAIT cycle, so TIMEOUT_CYC-1 marks the last one.
    assign w_timeout = (r_state == ST_WAIT) && (r_cnt == TIMEOUT_CYC - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_err <= '0;
        end else begin
            r_err <= '0;
            if (r_state == ST_ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt + 16'd1;
                if (!spi_done && w_timeout) begin
                    for (int unsigned i = 0; i < N_REQ; i++) begin
                        if (r_grant == 3'(i)) r_err[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = '0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_valid) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT:  if (spi_done || w_timeout) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_grant  <= '0;
            r_ack    <= '0;
            r_cmd    <= '0;
            r_wrdata <= '0;
            r_width  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_grant  <= w_idx;
                        r_cmd    <= w_sel_cmd;
                        r_wrdata <= w_sel_wrdata;
                        r_width  <= w_sel_width;
                    end
                end
                ST_WAIT: begin
                    if (spi_done) begin
                        for (int unsigned i = 0; i < N_REQ; i++) begin
                            if (r_grant == 3'(i)) r_ack[i] <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_ptr <= (r_grant == 3'(N_REQ - 1)) ? 3'd0 : r_grant + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign ack        = r_ack;
    assign busy       = (r_state != ST_IDLE);
    assign spi_start  = (r_state == ST_ISSUE);
    assign grant_id   = r_grant;
    assign spi_cmd    = r_cmd;
    assign spi_wrdata = r_wrdata;
    assign spi_width  = r_width;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
module tb_spi_txn_arbiter;
    import spi_cfg_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic [5:0]  req_cmd;
    logic [71:0] req_wrdata;
    logic [23:0] req_width;
    logic [2:0]  ack;
    logic [2:0]  err;
    logic        busy;
    logic [2:0]  grant_id;
    logic        spi_start;
    logic [1:0]  spi_cmd;
    logic [23:0] spi_wrdata;
    logic [7:0]  spi_width;
    logic        spi_done;

    int tests = 0;
    int fails = 0;

    spi_txn_arbiter #(.N_REQ(3), .DATA_W(24), .TIMEOUT_CYC(16'd10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_cmd    (req_cmd),
        .req_wrdata (req_wrdata),
        .req_width  (req_width),
        .ack        (ack),
        .err        (err),
        .busy       (busy),
        .grant_id   (grant_id),
        .spi_start  (spi_start),
        .spi_cmd    (spi_cmd),
        .spi_wrdata (spi_wrdata),
        .spi_width  (spi_width),
        .spi_done   (spi_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [2:0]  exp_grant [6] = '{3'd2, 3'd0, 3'd1, 3'd2, 3'd0, 3'd1};
    logic [23:0] exp_wd    [6] = '{24'h333333, 24'h111111, 24'h222222,
                                   24'h333333, 24'h111111, 24'h222222};
    logic [2:0]  exp_ack   [6] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010};

    initial begin
        rst_n      = 1'b0;
        req        = '0;
        req_cmd    = '0;
        req_wrdata = '0;
        req_width  = '0;
        spi_done   = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_start", 32'(spi_start), 32'h0);
        chk("rst_grant", 32'(grant_id), 32'h0);
        chk("rst_wrdata", 32'(spi_wrdata), 32'h0);
        rst_n = 1'b1;

        // Single request from requester 0
        req             = 3'b001;
        req_cmd[1:0]    = CMD_RD;
        req_wrdata[23:0] = 24'h000055;
        req_width[7:0]  = DEFAULT_WIDTH;
        tick();
        chk("t1_start", 32'(spi_start), 32'h1);
        chk("t1_wrdata", 32'(spi_wrdata), 32'h000055);
        chk("t1_width", 32'(spi_width), 32'd24);
        chk("t1_cmd", 32'(spi_cmd), 32'h1);
        chk("t1_busy", 32'(busy), 32'h1);
        chk("t1_grant", 32'(grant_id), 32'h0);
        tick();
        chk("t1_start_once", 32'(spi_start), 32'h0);
        repeat (28) tick();
        chk("t1_no_early_ack", 32'(ack), 32'h0);
        spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
        req      = '0;
        chk("t1_ack", 32'(ack), 32'b001);
        chk("t1_busy_done", 32'(busy), 32'h1);
        chk("t1_err", 32'(err), 32'h0);
        tick();
        chk("t1_ack_clear", 32'(ack), 32'h0);
        chk("t1_busy_low", 32'(busy), 32'h0);

        // Stray done in IDLE
        spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
        chk("stray_idle_busy", 32'(busy), 32'h0);
        chk("stray_idle_ack", 32'(ack), 32'h0);
        chk("stray_idle_start", 32'(spi_start), 32'h0);

        // ptr is 1: requester 2 alone wins; stray done in ISSUE, then reset in WAIT
        req                = 3'b100;
        req_cmd[5:4]       = CMD_WR;
        req_wrdata[71:48]  = 24'h333333;
        req_width[23:16]   = 8'd16;
        tick();
        chk("r_grant2", 32'(grant_id), 32'h2);
        chk("r_start", 32'(spi_start), 32'h1);
        spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
        chk("stray_issue_ack", 32'(ack), 32'h0);
        chk("stray_issue_busy", 32'(busy), 32'h1);
        tick();
        chk("stray_issue_ack2", 32'(ack), 32'h0);
        chk("r_width", 32'(spi_width), 32'd16);
        rst_n = 1'b0;
        #1;
        chk("rwait_busy", 32'(busy), 32'h0);
        chk("rwait_grant", 32'(grant_id), 32'h0);
        chk("rwait_wrdata", 32'(spi_wrdata), 32'h0);
        chk("rwait_width", 32'(spi_width), 32'h0);
        chk("rwait_ack", 32'(ack), 32'h0);
        req = 3'b110;
        req_wrdata[47:24] = 24'h222222;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rwait_after_grant", 32'(grant_id), 32'h1);
        chk("rwait_after_wd", 32'(spi_wrdata), 32'h222222);
        tick();
        spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
        chk("rwait_after_ack", 32'(ack), 32'b010);
        // All three request continuously from the DONE cycle on
        req               = 3'b111;
        req_wrdata[23:0]  = 24'h111111;

        for (int t = 0; t < 6; t++) begin
            tick();
            chk("fair_idle", 32'(busy), 32'h0);
            tick();
            chk("fair_grant", 32'(grant_id), 32'(exp_grant[t]));
            chk("fair_wd", 32'(spi_wrdata), 32'(exp_wd[t]));
            tick();
            spi_done = 1'b1;
            tick();
            spi_done = 1'b0;
            chk("fair_ack", 32'(ack), 32'(exp_ack[t]));
        end
        req = '0;
        tick();

        // Field isolation: ptr is 2, requester 0 alone wins
        req = 3'b001;
        tick();
        chk("iso_grant", 32'(grant_id), 32'h0);
        tick();
        req_wrdata[23:0]  = 24'h0F0F0F;
        req_wrdata[71:48] = 24'hABCDEF;
        tick();
        tick();
        chk("iso_wait_wd", 32'(spi_wrdata), 32'h111111);
        spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
        req      = '0;
        chk("iso_done_wd", 32'(spi_wrdata), 32'h111111);
        chk("iso_ack", 32'(ack), 32'b001);
        tick();
        chk("iso_idle_wd", 32'(spi_wrdata), 32'h111111);
        chk("iso_idle_busy", 32'(busy), 32'h0);

`ifdef SPI_ARB_TIMEOUT_EN
        // Timeout with no spi_done (ptr is 1, requester 0 alone wins)
        req = 3'b001;
        tick();
        tick();
        repeat (9) tick();
        chk("to_wait10_err", 32'(err), 32'h0);
        chk("to_wait10_busy", 32'(busy), 32'h1);
        tick();
        req = '0;
        chk("to_err", 32'(err), 32'b001);
        chk("to_no_ack", 32'(ack), 32'h0);
        tick();
        chk("to_err_clear", 32'(err), 32'h0);
        // spi_done on the 10th WAIT cycle wins over the limit
        req = 3'b001;
        tick();
        tick();
        repeat (9) tick();
        spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
        req      = '0;
        chk("to_edge_ack", 32'(ack), 32'b001);
        chk("to_edge_err", 32'(err), 32'h0);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
